// File: rtl/reg_bank_wr_arbiter.sv
// Round-robin write arbiter in front of a small register bank with a registered read port.
// One requester is accepted in IDLE, and its write is committed to the bank in the following COMMIT cycle.
module reg_bank_wr_arbiter #(
    parameter int REQ_NUM    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [REQ_NUM-1:0]            req_valid_i,
    output logic [REQ_NUM-1:0]            req_ready_o,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] req_dat_i,
    input  logic [ADDR_WIDTH-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0]         rd_dat_o,
    output logic                          wr_done_o,
    output logic [$clog2(REQ_NUM)-1:0]    grant_id_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int ID_W  = $clog2(REQ_NUM);

    typedef enum logic {
        IDLE,
        COMMIT
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ID_W-1:0]         ptr_q;
    logic [ID_W-1:0]         ptr_nxt;
    logic [ID_W-1:0]         win_id;
    logic                    win_found;
    logic                    accept;
    int                      idx;
    logic [ID_W-1:0]         stg_id;
    logic [ADDR_WIDTH-1:0]   stg_addr;
    logic [DATA_WIDTH-1:0]   stg_dat;
    logic [DATA_WIDTH-1:0]   bank [DEPTH];

    // Search ptr, ptr+1, ... with wrap at REQ_NUM (works for non power-of-two counts).
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= REQ_NUM) begin
                idx = idx - REQ_NUM;
            end
            if (!win_found && req_valid_i[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found && !rst_i) begin
                    req_ready_o[win_id] = 1'b1;
                    accept              = 1'b1;
                    state_d             = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ptr_nxt    = (stg_id == ID_W'(REQ_NUM - 1)) ? '0 : stg_id + 1'b1;
    assign grant_id_o = stg_id;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            stg_id    <= '0;
            stg_addr  <= '0;
            stg_dat   <= '0;
            wr_done_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_done_o <= accept;
            if (accept) begin
                stg_id   <= win_id;
                stg_addr <= req_addr_i[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
                stg_dat  <= req_dat_i[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state_q == COMMIT) begin
                ptr_q <= ptr_nxt;
            end
        end
    end

    // Read samples the bank before this edge's commit lands, so a same-cycle read sees the old word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
            rd_dat_o <= '0;
        end else begin
            rd_dat_o <= bank[rd_addr_i];
            if (state_q == COMMIT) begin
                bank[stg_addr] <= stg_dat;
            end
        end
    end

`ifndef SV_ASSRT_DISABLE
    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));
    a_done_single: assert property (@(posedge clk_i) disable iff (rst_i)
        wr_done_o |=> !wr_done_o);
    a_valid_known: assert property (@(posedge clk_i) disable iff (rst_i)
        !$isunknown(req_valid_i));
`endif

endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Directed bench for reg_bank_wr_arbiter: a table of single-shot arbitration vectors,
// followed by hand-written multi-cycle sequences.
module tb_reg_bank_wr_arbiter;

    localparam int RN = 4;
    localparam int DW = 32;
    localparam int AW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [RN-1:0]     req_valid;
    logic [RN-1:0]     req_ready;
    logic [RN*AW-1:0]  req_addr;
    logic [RN*DW-1:0]  req_dat;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_dat;
    logic              wr_done;
    logic [1:0]        grant_id;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  mask;
        int          win;
        logic [2:0]  addr;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl [12];

    localparam logic [3:0] RDY_SEQ [10] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                            4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

    reg_bank_wr_arbiter #(
        .REQ_NUM   (RN),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .req_dat_i  (req_dat),
        .rd_addr_i  (rd_addr),
        .rd_dat_o   (rd_dat),
        .wr_done_o  (wr_done),
        .grant_id_o (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [2:0] a, input logic [31:0] d);
        req_addr[k*AW +: AW] = a;
        req_dat[k*DW +: DW]  = d;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_rdy;

        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_dat   = '0;
        rd_addr   = '0;

        // Pointer starts at 0; requester k drives addr 2k, data C0DE_0000 | v<<4 | k.
        tbl[0]  = '{4'b0001,  0, 3'd0, 32'hC0DE_0000};
        tbl[1]  = '{4'b0001,  0, 3'd0, 32'hC0DE_0010};
        tbl[2]  = '{4'b1111,  1, 3'd2, 32'hC0DE_0021};
        tbl[3]  = '{4'b0011,  0, 3'd0, 32'hC0DE_0030};
        tbl[4]  = '{4'b1100,  2, 3'd4, 32'hC0DE_0042};
        tbl[5]  = '{4'b0110,  1, 3'd2, 32'hC0DE_0051};
        tbl[6]  = '{4'b1000,  3, 3'd6, 32'hC0DE_0063};
        tbl[7]  = '{4'b1010,  1, 3'd2, 32'hC0DE_0071};
        tbl[8]  = '{4'b1001,  3, 3'd6, 32'hC0DE_0083};
        tbl[9]  = '{4'b0100,  2, 3'd4, 32'hC0DE_0092};
        tbl[10] = '{4'b0111,  0, 3'd0, 32'hC0DE_00A0};
        tbl[11] = '{4'b0000, -1, 3'd0, 32'h0000_0000};

        tick();
        tick();
        chk("por_ready", 32'(req_ready), 32'h0);
        chk("por_wr_done", 32'(wr_done), 32'h0);
        chk("por_grant_id", 32'(grant_id), 32'h0);
        chk("por_rd_dat", rd_dat, 32'h0);
        rst = 1'b0;

        for (int v = 0; v < 12; v++) begin
            for (int k = 0; k < RN; k++) begin
                set_req(k, 3'(k * 2), 32'hC0DE_0000 | 32'(v << 4) | 32'(k));
            end
            req_valid = tbl[v].mask;
            #1;
            exp_rdy = (tbl[v].win < 0) ? 4'b0000 : 4'(1 << tbl[v].win);
            chk($sformatf("v%0d_ready", v), 32'(req_ready), 32'(exp_rdy));
            tick();
            req_valid = '0;
            #1;
            chk($sformatf("v%0d_wr_done", v), 32'(wr_done), (tbl[v].win < 0) ? 32'h0 : 32'h1);
            if (tbl[v].win >= 0) begin
                chk($sformatf("v%0d_grant_id", v), 32'(grant_id), 32'(tbl[v].win));
            end
            tick();
            if (tbl[v].win >= 0) begin
                rd_addr = tbl[v].addr;
                tick();
                chk($sformatf("v%0d_readback", v), rd_dat, tbl[v].dat);
            end
        end

        // Mid-simulation reset with requests pending: outputs held low, bank cleared.
        req_valid = 4'b1111;
        rst       = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wr_done", 32'(wr_done), 32'h0);
        chk("rst_rd_dat", rd_dat, 32'h0);
        tick();
        req_valid = '0;
        rst       = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            tick();
            chk($sformatf("rst_bank%0d", a), rd_dat, 32'h0);
        end

        // Single write and its read latency.
        set_req(0, 3'd3, 32'hDEAD_BEEF);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        rd_addr   = 3'd3;
        #1;
        chk("single_wr_done", 32'(wr_done), 32'h1);
        chk("single_grant_id", 32'(grant_id), 32'h0);
        chk("single_commit_ready", 32'(req_ready), 32'h0);
        tick();
        chk("single_rd_old", rd_dat, 32'h0);
        tick();
        chk("single_rd_new", rd_dat, 32'hDEAD_BEEF);

        // All four requesters continuously valid from ptr=0.
        apply_reset();
        for (int k = 0; k < RN; k++) begin
            set_req(k, 3'(k), 32'h100 + 32'(k));
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("rr%0d_ready", c), 32'(req_ready), 32'(RDY_SEQ[c]));
            chk($sformatf("rr%0d_wr_done", c), 32'(wr_done), 32'(c % 2));
            if (c % 2 == 1) begin
                chk($sformatf("rr%0d_grant_id", c), 32'(grant_id), 32'((c / 2) % 4));
            end
            tick();
        end
        req_valid = '0;

        // Same-address race: req1 then req2 both write addr 5.
        apply_reset();
        set_req(1, 3'd5, 32'h11);
        set_req(2, 3'd5, 32'h22);
        req_valid = 4'b0110;
        #1;
        chk("race_ready1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0100;
        #1;
        chk("race_wr_done1", 32'(wr_done), 32'h1);
        chk("race_grant1", 32'(grant_id), 32'h1);
        tick();
        #1;
        chk("race_ready2", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        #1;
        chk("race_grant2", 32'(grant_id), 32'h2);
        tick();
        rd_addr = 3'd5;
        tick();
        chk("race_bank5", rd_dat, 32'h22);

        // Read of addr 5 during the commit that overwrites it.
        set_req(0, 3'd5, 32'h33);
        req_valid = 4'b0001;
        #1;
        chk("rdw_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        rd_addr   = 3'd5;
        tick();
        chk("rdw_old", rd_dat, 32'h22);
        tick();
        chk("rdw_new", rd_dat, 32'h33);

        // Reset during COMMIT drops the write and restarts arbitration at requester 0.
        set_req(1, 3'd7, 32'h77);
        req_valid = 4'b0010;
        #1;
        chk("rc_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        #1;
        chk("rc_wr_done_pre", 32'(wr_done), 32'h1);
        rst = 1'b1;
        #1;
        chk("rc_wr_done_rst", 32'(wr_done), 32'h0);
        tick();
        rst     = 1'b0;
        rd_addr = 3'd7;
        tick();
        chk("rc_bank7", rd_dat, 32'h0);
        req_valid = 4'b1111;
        #1;
        chk("rc_ptr0_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("rc_grant0", 32'(grant_id), 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
